sd_block_dma: RTL and testbench

- Sector DMA engine between the byte-level SPI SD controller (sd) and CPU-side 8-bit RAM.
- On one start pulse it moves one data block in either direction:
  - Read: waits for the SD start token, then copies the block into RAM.
  - Write: fetches the block from RAM, sends it framed, then checks the card's data response and waits out busy.
- The CPU polls status through the port router.

---
 rtl/sd_block_dma.sv | 271 +++++++++++++++++++++++++++
 tb/tb_sd_block_dma.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sd_block_dma.sv
// Sector DMA between the byte-level SPI SD controller and 8-bit RAM; moves one block per start pulse.
// Optional CRC16-CCITT generation/check of the data field is enabled by defining SD_DMA_CRC_EN.
//
// state   | meaning
// IDLE    | waiting for start
// R_TOKEN | polling 0xFF until the 0xFE start token arrives
// R_DATA  | receiving one data byte
// R_WR    | writing the received byte to RAM
// R_CRC   | receiving the two CRC bytes
// W_TOKEN | sending the 0xFE start token
// W_FETCH | RAM read request for the next byte
// W_LATCH | capturing RAM read data
// W_DATA  | sending one data byte
// W_CRC   | sending the two CRC bytes
// W_RESP  | reading the card's data response
// W_BUSY  | polling until the card releases busy
// FIN     | one-cycle done, result in error
module sd_block_dma #(
  parameter int BLOCK_LEN   = 512,
  parameter int TOKEN_TRIES = 4096,
  parameter int ADDR_W      = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic              dir,
  input  logic [ADDR_W-1:0] base,
  output logic              busy,
  output logic              done,
  output logic [1:0]        error,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [7:0]        mem_wdata,
  output logic              mem_re,
  input  logic [7:0]        mem_rdata,
  output logic              sd_signal,
  output logic [1:0]        sd_cmd,
  output logic [7:0]        sd_out,
  input  logic [7:0]        sd_din,
  input  logic              sd_busy,
  input  logic              sd_timeout
);

  localparam int CNT_W = $clog2(BLOCK_LEN + 1);
  localparam int TRY_W = $clog2(TOKEN_TRIES + 1);
  localparam logic [CNT_W-1:0] LAST_BYTE = CNT_W'(BLOCK_LEN - 1);

  typedef enum logic [3:0] {
    IDLE, R_TOKEN, R_DATA, R_WR, R_CRC,
    W_TOKEN, W_FETCH, W_LATCH, W_DATA, W_CRC, W_RESP, W_BUSY, FIN
  } state_t;

  typedef enum logic [1:0] {EX_ISSUE, EX_ACK, EX_WAIT} ex_t;

  state_t state, next_state;
  ex_t    ex_state, next_ex;

  logic [ADDR_W-1:0] base_q;
  logic [CNT_W-1:0]  cnt;
  logic [TRY_W-1:0]  tries;
  logic [7:0]        rx_q;
  logic [7:0]        tx_q;
  logic              crc_second;
  logic [1:0]        error_q;

  logic       accept;
  logic       xchg;
  logic       capture;
  logic       set_err;
  logic [1:0] err_code;
  logic [7:0] crc_tx_byte;
  logic       crc_bad;

`ifdef SD_DMA_CRC_EN
  logic [15:0] crc;
  logic [7:0]  crc_rx_hi;

  function automatic logic [15:0] crc16_byte(input logic [15:0] c, input logic [7:0] d);
    logic [15:0] r;
    logic        fb;
    r = c;
    for (int i = 7; i >= 0; i--) begin
      fb = r[15] ^ d[i];
      r  = {r[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
    end
    return r;
  endfunction

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      crc       <= '0;
      crc_rx_hi <= '0;
    end else begin
      if (accept)
        crc <= '0;
      else if (capture && state == R_DATA)
        crc <= crc16_byte(crc, sd_din);
      else if (capture && state == W_DATA)
        crc <= crc16_byte(crc, tx_q);
      if (capture && state == R_CRC && !crc_second)
        crc_rx_hi <= sd_din;
    end
  end

  assign crc_tx_byte = crc_second ? crc[7:0] : crc[15:8];
  assign crc_bad     = ({crc_rx_hi, sd_din} != crc);
`else
  assign crc_tx_byte = 8'hFF;
  assign crc_bad     = 1'b0;
`endif

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      ex_state <= EX_ISSUE;
    end else begin
      state    <= next_state;
      ex_state <= next_ex;
    end
  end

  always_comb begin
    next_state = state;
    next_ex    = ex_state;
    accept     = 1'b0;
    xchg       = 1'b0;
    capture    = 1'b0;
    set_err    = 1'b0;
    err_code   = 2'd0;
    sd_signal  = 1'b0;
    sd_out     = 8'hFF;
    mem_we     = 1'b0;
    mem_re     = 1'b0;
    done       = 1'b0;

    case (state)
      IDLE, FIN: begin
        done = (state == FIN);
        if (start) begin
          accept     = 1'b1;
          next_state = dir ? W_TOKEN : R_TOKEN;
        end else begin
          next_state = IDLE;
        end
      end
      R_TOKEN, R_DATA, R_CRC, W_RESP, W_BUSY: xchg = 1'b1;
      W_TOKEN: begin
        xchg   = 1'b1;
        sd_out = 8'hFE;
      end
      W_DATA: begin
        xchg   = 1'b1;
        sd_out = tx_q;
      end
      W_CRC: begin
        xchg   = 1'b1;
        sd_out = crc_tx_byte;
      end
      R_WR: begin
        mem_we     = 1'b1;
        next_state = (cnt == LAST_BYTE) ? R_CRC : R_DATA;
      end
      W_FETCH: begin
        mem_re     = 1'b1;
        next_state = W_LATCH;
      end
      W_LATCH: next_state = W_DATA;
      default: next_state = IDLE;
    endcase

    // Every SD byte goes through issue -> wait for busy rise -> wait for busy fall.
    if (xchg) begin
      case (ex_state)
        EX_ISSUE: begin
          sd_signal = 1'b1;
          next_ex   = EX_ACK;
        end
        EX_ACK: if (sd_busy) next_ex = EX_WAIT;
        EX_WAIT: if (!sd_busy) begin
          capture = 1'b1;
          next_ex = EX_ISSUE;
        end
        default: next_ex = EX_ISSUE;
      endcase
    end

    if (capture) begin
      case (state)
        R_TOKEN:
          if (sd_din == 8'hFE) next_state = R_DATA;
          else if (tries == TRY_W'(1)) begin
            next_state = FIN;
            set_err    = 1'b1;
            err_code   = 2'd1;
          end
        R_DATA:  next_state = R_WR;
        R_CRC:
          if (crc_second) begin
            next_state = FIN;
            if (crc_bad) begin
              set_err  = 1'b1;
              err_code = 2'd3;
            end
          end
        W_TOKEN: next_state = W_FETCH;
        W_DATA:  next_state = (cnt == LAST_BYTE) ? W_CRC : W_FETCH;
        W_CRC:   if (crc_second) next_state = W_RESP;
        W_RESP:
          if ((sd_din & 8'h1F) == 8'h05) next_state = W_BUSY;
          else begin
            next_state = FIN;
            set_err    = 1'b1;
            err_code   = 2'd2;
          end
        W_BUSY:
          if (sd_din != 8'h00) next_state = FIN;
          else if (tries == TRY_W'(1)) begin
            next_state = FIN;
            set_err    = 1'b1;
            err_code   = 2'd1;
          end
        default: ;
      endcase
      if (sd_timeout) begin
        next_state = FIN;
        set_err    = 1'b1;
        err_code   = 2'd1;
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      base_q     <= '0;
      cnt        <= '0;
      tries      <= '0;
      rx_q       <= '0;
      tx_q       <= '0;
      crc_second <= 1'b0;
      error_q    <= 2'd0;
    end else begin
      if (accept) begin
        base_q     <= base;
        cnt        <= '0;
        tries      <= TRY_W'(TOKEN_TRIES);
        crc_second <= 1'b0;
        error_q    <= 2'd0;
      end
      if (set_err) error_q <= err_code;
      if (state == R_WR) cnt <= cnt + 1'b1;
      if (state == W_LATCH) tx_q <= mem_rdata;
      if (capture) begin
        case (state)
          R_TOKEN, W_BUSY: tries <= tries - 1'b1;
          R_DATA:          rx_q <= sd_din;
          W_DATA:          cnt <= cnt + 1'b1;
          W_RESP:          tries <= TRY_W'(TOKEN_TRIES);
          R_CRC, W_CRC:    crc_second <= ~crc_second;
          default: ;
        endcase
      end
    end
  end

  assign busy      = (state != IDLE) && (state != FIN);
  assign error     = error_q;
  assign mem_addr  = base_q + ADDR_W'(cnt);
  assign mem_wdata = rx_q;
  assign sd_cmd    = 2'b00;

endmodule

// File: tb/tb_sd_block_dma.sv
// Scoreboard bench for sd_block_dma: an SD byte model and a RAM model check MOSI bytes and RAM writes
// against queues filled when each transfer is set up.
module tb_sd_block_dma;
  localparam int BLOCK_LEN   = 512;
  localparam int TOKEN_TRIES = 4096;
  localparam int ADDR_W      = 16;

  logic              clock = 1'b0;
  logic              reset = 1'b1;
  logic              start = 1'b0;
  logic              dir   = 1'b0;
  logic [ADDR_W-1:0] base  = '0;
  logic              busy, done, mem_we, mem_re, sd_signal;
  logic [1:0]        error, sd_cmd;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_wdata, sd_out;
  logic [7:0]        mem_rdata  = 8'h00;
  logic [7:0]        sd_din     = 8'hFF;
  logic              sd_busy    = 1'b0;
  logic              sd_timeout = 1'b0;

  sd_block_dma #(.BLOCK_LEN(BLOCK_LEN), .TOKEN_TRIES(TOKEN_TRIES), .ADDR_W(ADDR_W)) dut (
    .clock(clock), .reset(reset), .start(start), .dir(dir), .base(base),
    .busy(busy), .done(done), .error(error),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_re(mem_re), .mem_rdata(mem_rdata),
    .sd_signal(sd_signal), .sd_cmd(sd_cmd), .sd_out(sd_out), .sd_din(sd_din),
    .sd_busy(sd_busy), .sd_timeout(sd_timeout)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  logic [7:0]  ram [0:65535];
  logic [7:0]  resp_q[$];
  logic [7:0]  mosi_q[$];
  logic [15:0] we_addr_q[$];
  logic [7:0]  we_data_q[$];
  logic [7:0]  resp_default = 8'hFF;
  int          lat = 0, pulses = 0, we_cnt = 0, re_cnt = 0, both_cnt = 0, done_cnt = 0, sig_overlap = 0;
  logic        rd_pend = 1'b0;
  logic [15:0] rd_addr = '0;
  logic [7:0]  mon_tmp;
  logic [15:0] mon_addr;

  function automatic logic [15:0] crc_upd(input logic [15:0] c, input logic [7:0] b);
    logic [15:0] r;
    r = c ^ {b, 8'h00};
    for (int k = 0; k < 8; k++) r = r[15] ? ((r << 1) ^ 16'h1021) : (r << 1);
    return r;
  endfunction

  // SD byte model and RAM model, both acting on the falling edge.
  initial begin
    forever begin
      @(negedge clock);
      if (reset) begin
        sd_busy = 1'b0;
        lat     = 0;
        rd_pend = 1'b0;
      end else begin
        if (rd_pend) begin
          mem_rdata = ram[rd_addr];
          rd_pend   = 1'b0;
        end
        if (mem_re) begin
          rd_pend = 1'b1;
          rd_addr = mem_addr;
          re_cnt++;
        end
        if (mem_we && mem_re) both_cnt++;
        if (mem_we) begin
          we_cnt++;
          ram[mem_addr] = mem_wdata;
          check("we_expected", we_addr_q.size() != 0, 1);
          if (we_addr_q.size() != 0) begin
            mon_addr = we_addr_q.pop_front();
            mon_tmp  = we_data_q.pop_front();
            check("we_addr", mem_addr, mon_addr);
            check("we_data", mem_wdata, mon_tmp);
          end
        end
        if (done) done_cnt++;
        if (sd_signal) begin
          pulses++;
          if (sd_busy) sig_overlap++;
          if (mosi_q.size() != 0) begin
            mon_tmp = mosi_q.pop_front();
            check("mosi", sd_out, mon_tmp);
          end
          sd_busy = 1'b1;
          lat     = 2;
        end else if (sd_busy) begin
          if (lat == 0) begin
            sd_busy = 1'b0;
            if (resp_q.size() != 0) sd_din = resp_q.pop_front();
            else sd_din = resp_default;
          end else begin
            lat--;
          end
        end
      end
    end
  end

  task automatic clear_stats();
    pulses = 0; we_cnt = 0; re_cnt = 0; both_cnt = 0; done_cnt = 0; sig_overlap = 0;
  endtask

  task automatic check_reset_outputs();
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_error", error, 0);
    check("rst_mem_we", mem_we, 0);
    check("rst_mem_re", mem_re, 0);
    check("rst_sd_signal", sd_signal, 0);
    check("rst_sd_cmd", sd_cmd, 0);
    check("rst_sd_out", sd_out, 8'hFF);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_mem_wdata", mem_wdata, 0);
  endtask

  task automatic run_xfer(input logic d, input logic [15:0] b, input int budget, output logic [1:0] err_o);
    int cyc;
    @(negedge clock);
    start = 1'b1; dir = d; base = b;
    @(negedge clock);
    start = 1'b0;
    check("busy_after_start", busy, 1);
    check("error_cleared", error, 0);
    cyc = 0;
    while (!done && cyc < budget) begin
      @(negedge clock);
      cyc++;
    end
    check("done_in_time", done, 1);
    check("busy_at_done", busy, 0);
    err_o = error;
    @(negedge clock);
    check("done_one_cycle", done, 0);
  endtask

  task automatic push_read_block(input logic [15:0] b, input logic [7:0] xor_pat, input logic corrupt);
    logic [15:0] crc;
    logic [7:0]  v;
    crc = '0;
    for (int i = 0; i < 3; i++) resp_q.push_back(8'hFF);
    resp_q.push_back(8'hFE);
    for (int i = 0; i < BLOCK_LEN; i++) begin
      v = 8'(i) ^ xor_pat;
      resp_q.push_back(v);
      crc = crc_upd(crc, v);
      we_addr_q.push_back(16'(b + 16'(i)));
      we_data_q.push_back(v);
    end
    resp_q.push_back(crc[15:8]);
    resp_q.push_back(crc[7:0] ^ {7'd0, corrupt});
    for (int i = 0; i < BLOCK_LEN + 6; i++) mosi_q.push_back(8'hFF);
  endtask

  task automatic push_write_block(input logic [15:0] b, input logic [7:0] resp_byte, input int busy_zeros);
    logic [15:0] crc;
    crc = '0;
    mosi_q.push_back(8'hFE);
    for (int i = 0; i < BLOCK_LEN; i++) begin
      mosi_q.push_back(ram[16'(b + 16'(i))]);
      crc = crc_upd(crc, ram[16'(b + 16'(i))]);
    end
`ifdef SD_DMA_CRC_EN
    mosi_q.push_back(crc[15:8]);
    mosi_q.push_back(crc[7:0]);
`else
    mosi_q.push_back(8'hFF);
    mosi_q.push_back(8'hFF);
`endif
    mosi_q.push_back(8'hFF);
    for (int i = 0; i < BLOCK_LEN + 3; i++) resp_q.push_back(8'hFF);
    resp_q.push_back(resp_byte);
    for (int i = 0; i < busy_zeros; i++) begin
      resp_q.push_back(8'h00);
      mosi_q.push_back(8'hFF);
    end
    resp_q.push_back(8'hFF);
    mosi_q.push_back(8'hFF);
  endtask

  initial begin
    logic [1:0] err;
    int         cyc, snap_p, snap_w, snap_d;

    repeat (3) @(negedge clock);
    check_reset_outputs();
    reset = 1'b0;
    repeat (2) @(negedge clock);

    // Read OK
    clear_stats();
    push_read_block(16'h1000, 8'h00, 1'b0);
    run_xfer(1'b0, 16'h1000, 20000, err);
    check("rd_err", err, 0);
    check("rd_pulses", pulses, BLOCK_LEN + 6);
    check("rd_we_cnt", we_cnt, BLOCK_LEN);
    check("rd_we_left", we_addr_q.size(), 0);
    check("rd_mosi_left", mosi_q.size(), 0);
    check("rd_done_cnt", done_cnt, 1);
    check("rd_ram_1080", ram[16'h1080], 8'h80);

    // Token timeout
    clear_stats();
    resp_q.delete();
    run_xfer(1'b0, 16'h1000, 30000, err);
    check("tmo_err", err, 1);
    check("tmo_pulses", pulses, TOKEN_TRIES);
    check("tmo_we_cnt", we_cnt, 0);
    repeat (5) @(negedge clock);
    check("tmo_err_hold", error, 1);

    // Write OK
    for (int i = 0; i < BLOCK_LEN; i++) ram[16'h2000 + 16'(i)] = ~8'(i);
    clear_stats();
    push_write_block(16'h2000, 8'hE5, 5);
    run_xfer(1'b1, 16'h2000, 20000, err);
    check("wr_err", err, 0);
    check("wr_pulses", pulses, BLOCK_LEN + 10);
    check("wr_re_cnt", re_cnt, BLOCK_LEN);
    check("wr_we_cnt", we_cnt, 0);
    check("wr_we_re_both", both_cnt, 0);
    check("wr_mosi_left", mosi_q.size(), 0);

    // Write reject: no busy-phase exchanges
    clear_stats();
    mosi_q.delete();
    resp_q.delete();
    push_write_block(16'h2000, 8'h0B, 0);
    void'(mosi_q.pop_back());
    run_xfer(1'b1, 16'h2000, 20000, err);
    check("rej_err", err, 2);
    check("rej_pulses", pulses, BLOCK_LEN + 4);
    check("rej_mosi_left", mosi_q.size(), 0);
    resp_q.delete();

    // Address wrap
    clear_stats();
    push_read_block(16'hFF00, 8'h5A, 1'b0);
    run_xfer(1'b0, 16'hFF00, 20000, err);
    check("wrap_err", err, 0);
    check("wrap_we_cnt", we_cnt, BLOCK_LEN);
    check("wrap_we_left", we_addr_q.size(), 0);
    check("wrap_ram_0000", ram[16'h0000], 8'h00 ^ 8'h5A);

`ifdef SD_DMA_CRC_EN
    clear_stats();
    push_read_block(16'h5000, 8'h00, 1'b0);
    run_xfer(1'b0, 16'h5000, 20000, err);
    check("crc_rd_ok_err", err, 0);
    clear_stats();
    push_read_block(16'h5000, 8'h00, 1'b1);
    run_xfer(1'b0, 16'h5000, 20000, err);
    check("crc_rd_bad_err", err, 3);
    check("crc_rd_bad_we", we_cnt, BLOCK_LEN);
    for (int i = 0; i < BLOCK_LEN; i++) ram[16'h4000 + 16'(i)] = 8'h00;
    clear_stats();
    mosi_q.delete();
    push_write_block(16'h4000, 8'hE5, 0);
    run_xfer(1'b1, 16'h4000, 20000, err);
    check("crc_wr_err", err, 0);
    check("crc_wr_mosi_left", mosi_q.size(), 0);
`endif

    // Reset in the middle of a read
    clear_stats();
    mosi_q.delete();
    resp_q.delete();
    push_read_block(16'h3000, 8'h33, 1'b0);
    @(negedge clock);
    start = 1'b1; dir = 1'b0; base = 16'h3000;
    @(negedge clock);
    start = 1'b0;
    cyc = 0;
    while (we_cnt < 100 && cyc < 5000) begin
      @(negedge clock);
      cyc++;
    end
    check("rst_reached_byte100", we_cnt >= 100, 1);
    reset = 1'b1;
    #1;
    check_reset_outputs();
    resp_q.delete();
    mosi_q.delete();
    we_addr_q.delete();
    we_data_q.delete();
    repeat (3) @(negedge clock);
    reset = 1'b0;
    snap_p = pulses; snap_w = we_cnt; snap_d = done_cnt;
    repeat (300) @(negedge clock);
    check("rst_no_pulses", pulses, snap_p);
    check("rst_no_we", we_cnt, snap_w);
    check("rst_no_done", done_cnt, snap_d);
    check("rst_idle_busy", busy, 0);

    check("sig_overlap", sig_overlap, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
